// File: rtl/udpoti_decoder_if.sv
// Host-side register interface of the up/down potentiometer decoder:
// load strobe in, wiper position and status pulses out.
interface udpoti_decoder_if;
  logic        load;
  logic [31:0] load_value;
  logic [31:0] value;
  logic        step;
  logic        blocked;
  logic        at_min;
  logic        at_max;

  modport master (
    output load, load_value,
    input  value, step, blocked, at_min, at_max
  );

  modport slave (
    input  load, load_value,
    output value, step, blocked, at_min, at_max
  );
endinterface

// File: rtl/udpoti_decoder.sv
// Up/down digital-potentiometer receiver: synchronises and filters the pin lines,
// counts falling INCREMENT edges and keeps a clamped 32-bit wiper position.
module udpoti_decoder #(
  parameter int RESOLUTION = 100,
  parameter int INIT_VALUE = 0,
  parameter int FILTER     = 16,
  parameter int USE_SELECT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              updown,
  input  logic              increment,
  input  logic              select,
  udpoti_decoder_if.slave   host
);

  localparam int                 CNT_W  = $clog2(FILTER + 1);
  localparam logic [31:0]        RES_C  = 32'(RESOLUTION);
  localparam logic [31:0]        INIT_C = 32'(INIT_VALUE);
  localparam logic [CNT_W-1:0]   FILT_C = CNT_W'(FILTER);
  // Bit order {select, updown, increment}; select idles high (deselected).
  localparam logic [2:0]         IDLE_C = 3'b100;

  logic [2:0]       pins_s;
  logic [2:0]       sync1_r;
  logic [2:0]       sync2_r;
  logic [2:0]       filt_r;
  logic [CNT_W-1:0] cnt_r [3];
  logic             inc_prev_r;
  logic             counted_s;
  logic [31:0]      next_value_s;
  logic             next_step_s;
  logic             next_blocked_s;
  logic [31:0]      value_r;
  logic             step_r;
  logic             blocked_r;
  logic             at_min_r;
  logic             at_max_r;

  assign pins_s = {select, updown, increment};

  // Two-flop synchroniser for the three asynchronous pin lines
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= IDLE_C;
      sync2_r <= IDLE_C;
    end else begin
      sync1_r <= pins_s;
      sync2_r <= sync1_r;
    end
  end

  // Per-line stability filter: output follows only after FILTER+1 differing cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_r <= IDLE_C;
      for (int i = 0; i < 3; i++) begin
        cnt_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] != filt_r[i]) begin
          if (cnt_r[i] == FILT_C) begin
            filt_r[i] <= sync2_r[i];
            cnt_r[i]  <= '0;
          end else begin
            cnt_r[i]  <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          cnt_r[i] <= '0;
        end
      end
    end
  end

  // Previous filtered increment for falling-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      inc_prev_r <= 1'b0;
    end else begin
      inc_prev_r <= filt_r[0];
    end
  end

  // Edge qualification and next wiper position; load wins over a same-cycle edge
  always_comb begin
    next_value_s   = value_r;
    next_step_s    = 1'b0;
    next_blocked_s = 1'b0;
    if (USE_SELECT != 0) begin
      counted_s = inc_prev_r & ~filt_r[0] & ~filt_r[2];
    end else begin
      counted_s = inc_prev_r & ~filt_r[0];
    end
    if (host.load) begin
      next_value_s = (host.load_value > RES_C) ? RES_C : host.load_value;
    end else if (counted_s) begin
      if (filt_r[1]) begin
        if (value_r < RES_C) begin
          next_value_s = value_r + 32'd1;
          next_step_s  = 1'b1;
        end else begin
          next_blocked_s = 1'b1;
        end
      end else begin
        if (value_r != 32'd0) begin
          next_value_s = value_r - 32'd1;
          next_step_s  = 1'b1;
        end else begin
          next_blocked_s = 1'b1;
        end
      end
    end else begin
      next_value_s = value_r;
    end
  end

  // Registered wiper position, pulses and limit flags
  always_ff @(posedge clk) begin
    if (rst) begin
      value_r   <= INIT_C;
      step_r    <= 1'b0;
      blocked_r <= 1'b0;
      at_min_r  <= (INIT_C == 32'd0);
      at_max_r  <= (INIT_C == RES_C);
    end else begin
      value_r   <= next_value_s;
      step_r    <= next_step_s;
      blocked_r <= next_blocked_s;
      at_min_r  <= (next_value_s == 32'd0);
      at_max_r  <= (next_value_s == RES_C);
    end
  end

  assign host.value   = value_r;
  assign host.step    = step_r;
  assign host.blocked = blocked_r;
  assign host.at_min  = at_min_r;
  assign host.at_max  = at_max_r;

endmodule

// File: tb/tb_udpoti_decoder.sv
// Scoreboard bench for udpoti_decoder: directed pin sequences push expected
// step/blocked events; monitors pop and compare on every output pulse.
module tb_udpoti_decoder;

  typedef struct {
    logic        is_step;
    logic [31:0] val;
    int          cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ud0 = 1'b0, inc0 = 1'b0, sel0 = 1'b1;
  logic ud1 = 1'b0, inc1 = 1'b0, sel1 = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_step0 = 0;
  int n_blk0 = 0;
  int m0 = 0;
  int m1 = 5;
  ev_t q0[$];
  ev_t q1[$];

  udpoti_decoder_if h0 ();
  udpoti_decoder_if h1 ();

  udpoti_decoder #(.RESOLUTION(100), .INIT_VALUE(0), .FILTER(16), .USE_SELECT(0)) dut0 (
    .clk(clk), .rst(rst), .updown(ud0), .increment(inc0), .select(sel0), .host(h0)
  );

  udpoti_decoder #(.RESOLUTION(100), .INIT_VALUE(5), .FILTER(16), .USE_SELECT(1)) dut1 (
    .clk(clk), .rst(rst), .updown(ud1), .increment(inc1), .select(sel1), .host(h1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference behaviour of one counted edge; update lands 20 negedges after the drive point.
  task automatic push_ev(input int which, input logic dir);
    ev_t e;
    int m;
    m = (which == 0) ? m0 : m1;
    e.is_step = 1'b0;
    if (dir) begin
      if (m < 100) begin
        m = m + 1;
        e.is_step = 1'b1;
      end
    end else begin
      if (m > 0) begin
        m = m - 1;
        e.is_step = 1'b1;
      end
    end
    e.val = 32'(m);
    e.cyc = cyc + 20;
    if (which == 0) begin
      m0 = m;
      q0.push_back(e);
    end else begin
      m1 = m;
      q1.push_back(e);
    end
  endtask

  task automatic do_step(input int which, input logic dir, input logic counted);
    if (which == 0) begin
      ud0 = dir;
      inc0 = 1'b1;
    end else begin
      ud1 = dir;
      inc1 = 1'b1;
    end
    tick(40);
    if (counted) push_ev(which, dir);
    if (which == 0) inc0 = 1'b0;
    else inc1 = 1'b0;
    tick(40);
  endtask

  task automatic load0(input logic [31:0] v);
    h0.load = 1'b1;
    h0.load_value = v;
    tick(1);
    h0.load = 1'b0;
    m0 = (v > 32'd100) ? 100 : int'(v);
    chk("load_value", h0.value, 32'(m0));
  endtask

  always @(negedge clk) begin
    if (!rst && (h0.step || h0.blocked)) begin
      if (h0.step) n_step0 = n_step0 + 1;
      if (h0.blocked) n_blk0 = n_blk0 + 1;
      chk("dut0_exclusive", {31'd0, h0.step & h0.blocked}, 32'd0);
      if (q0.size() == 0) begin
        chk("dut0_unexpected_pulse", {31'd0, h0.step}, 32'hFFFF_FFFF);
      end else begin
        ev_t e;
        e = q0.pop_front();
        chk("dut0_kind", {31'd0, h0.step}, {31'd0, e.is_step});
        chk("dut0_value", h0.value, e.val);
        chk("dut0_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (h1.step || h1.blocked)) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_pulse", {31'd0, h1.step}, 32'hFFFF_FFFF);
      end else begin
        ev_t e;
        e = q1.pop_front();
        chk("dut1_kind", {31'd0, h1.step}, {31'd0, e.is_step});
        chk("dut1_value", h1.value, e.val);
        chk("dut1_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    int bs, bb;
    h0.load = 1'b0;
    h0.load_value = 32'd0;
    h1.load = 1'b0;
    h1.load_value = 32'd0;
    rst = 1'b1;
    tick(3);
    chk("rst_value", h0.value, 32'd0);
    chk("rst_at_min", {31'd0, h0.at_min}, 32'd1);
    chk("rst_at_max", {31'd0, h0.at_max}, 32'd0);
    chk("rst_step", {31'd0, h0.step}, 32'd0);
    chk("rst_blocked", {31'd0, h0.blocked}, 32'd0);
    chk("rst_value_init5", h1.value, 32'd5);
    chk("rst_at_min_init5", {31'd0, h1.at_min}, 32'd0);
    rst = 1'b0;
    tick(5);

    bs = n_step0;
    for (int i = 0; i < 10; i++) do_step(0, 1'b1, 1'b1);
    chk("up10_value", h0.value, 32'd10);
    chk("up10_steps", 32'(n_step0 - bs), 32'd10);

    load0(32'd99);
    bs = n_step0; bb = n_blk0;
    for (int i = 0; i < 3; i++) do_step(0, 1'b1, 1'b1);
    chk("top_value", h0.value, 32'd100);
    chk("top_at_max", {31'd0, h0.at_max}, 32'd1);
    chk("top_steps", 32'(n_step0 - bs), 32'd1);
    chk("top_blocked", 32'(n_blk0 - bb), 32'd2);

    load0(32'd2);
    bs = n_step0; bb = n_blk0;
    for (int i = 0; i < 5; i++) do_step(0, 1'b0, 1'b1);
    chk("bottom_value", h0.value, 32'd0);
    chk("bottom_at_min", {31'd0, h0.at_min}, 32'd1);
    chk("bottom_steps", 32'(n_step0 - bs), 32'd2);
    chk("bottom_blocked", 32'(n_blk0 - bb), 32'd3);

    load0(32'd50);
    bs = n_step0; bb = n_blk0;
    ud0 = 1'b1;
    inc0 = 1'b1;
    tick(40);
    inc0 = 1'b0;
    tick(8);
    inc0 = 1'b1;
    tick(40);
    ud0 = 1'b0;
    tick(8);
    ud0 = 1'b1;
    tick(40);
    chk("glitch_value", h0.value, 32'd50);
    chk("glitch_pulses", 32'(n_step0 - bs + n_blk0 - bb), 32'd0);
    push_ev(0, 1'b1);
    inc0 = 1'b0;
    tick(40);
    chk("after_glitch_value", h0.value, 32'd51);

    ud0 = 1'b1;
    inc0 = 1'b1;
    tick(40);
    inc0 = 1'b0;
    tick(19);
    h0.load = 1'b1;
    h0.load_value = 32'd500;
    tick(1);
    h0.load = 1'b0;
    m0 = 100;
    chk("load_prio_value", h0.value, 32'd100);
    chk("load_prio_step", {31'd0, h0.step}, 32'd0);
    chk("load_prio_at_max", {31'd0, h0.at_max}, 32'd1);
    tick(40);

    load0(32'd30);
    ud0 = 1'b0;
    inc0 = 1'b1;
    tick(40);
    inc0 = 1'b0;
    tick(10);
    rst = 1'b1;
    tick(2);
    m0 = 0;
    chk("midstep_rst_value", h0.value, 32'd0);
    chk("midstep_rst_at_min", {31'd0, h0.at_min}, 32'd1);
    rst = 1'b0;
    tick(60);
    chk("after_rst_value", h0.value, 32'd0);

    sel1 = 1'b1;
    for (int i = 0; i < 4; i++) do_step(1, 1'b1, 1'b0);
    chk("deselected_value", h1.value, 32'd5);
    sel1 = 1'b0;
    tick(40);
    for (int i = 0; i < 4; i++) do_step(1, 1'b1, 1'b1);
    chk("selected_value", h1.value, 32'd9);

    tick(5);
    chk("dut0_queue_empty", 32'(q0.size()), 32'd0);
    chk("dut1_queue_empty", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
